fxp_display_scan_ctrl: RTL

//  Accepts one unsigned fixed-point result per valid/ready handshake and converts it sequentially
//  (no real arithmetic) to four decimal digits: integer tens, integer ones, tenths, hundredths.

---
 rtl/fxp_disp_pkg.sv | 27 ++
 rtl/seg7_encoder.sv | 21 ++
 rtl/fxp_display_scan_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fxp_disp_pkg.sv
// Shared types and constants for the fixed-point display scan controller.
// Build option: FXP_SIM_DIGITS_EN selects the simulation-friendly blank code.
package fxp_disp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFrac1,
    StFrac2,
    StInt,
    StCommit
  } state_e;

`ifdef FXP_SIM_DIGITS_EN
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
`else
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
`endif

  // Active-low a..g, bit 6 = a, bit 0 = g.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  localparam logic [3:0] DIG_SEL_RESET = 4'b0001;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational digit-to-segment encoder.
// Ports: digit (BCD digit), blank (force blank code), seg (7-bit segment code).
// Build option: FXP_SIM_DIGITS_EN emits {3'b000, digit} (blank = 0) instead of segment patterns.
module seg7_encoder
  import fxp_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
`ifdef FXP_SIM_DIGITS_EN
    if (!blank) seg = {3'b000, digit};
`else
    if (!blank && (digit <= 4'd9)) seg = SEG_TABLE[digit];
`endif
  end

endmodule

// File: rtl/fxp_display_scan_ctrl.sv
// Converts an unsigned fixed-point value to four decimal digits (tens, ones, tenths,
// hundredths) without real arithmetic, then scans them onto a shared 7-segment bus.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data handshake; busy;
//        seg, dp, dig_sel (registered; dig_sel one-hot [3]=tens .. [0]=hundredths).
// Build option: FXP_SIM_DIGITS_EN changes only the seg encoding (see seg7_encoder).
module fxp_display_scan_ctrl
  import fxp_disp_pkg::*;
#(
  parameter int unsigned INT_W    = 4,
  parameter int unsigned FRAC_W   = 4,
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INT_W+FRAC_W-1:0] in_data,
  output logic                    busy,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [3:0]              dig_sel
);

  localparam int unsigned DataW = INT_W + FRAC_W;
  localparam int unsigned CntW  = $clog2(SCAN_DIV);
  // Remainder must be able to hold the constant 10 even for narrow integers.
  localparam int unsigned RemW  = (INT_W < 4) ? 4 : INT_W;
  localparam int unsigned PW    = FRAC_W + 4;

  state_e state_q, state_d;

  logic [FRAC_W-1:0] frac_q, rem_q;
  logic [RemW-1:0]   int_rem_q;
  logic [3:0]        tens_sh_q, ones_sh_q, tenths_sh_q, hund_sh_q;
  logic [3:0]        tens_q, ones_q, tenths_q, hund_q;
  logic [PW-1:0]     frac_x10, rem_x10;
  logic              accept, int_done;
  logic              unused_rem_lsbs;

  assign accept          = in_valid && in_ready;
  assign int_done        = int_rem_q < RemW'(10);
  assign frac_x10        = PW'(frac_q) * PW'(10);
  assign rem_x10         = PW'(rem_q) * PW'(10);
  assign unused_rem_lsbs = ^rem_x10[FRAC_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StFrac1;
      StFrac1:  state_d = StFrac2;
      StFrac2:  state_d = StInt;
      StInt:    if (int_done) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs; ready is held low while reset is asserted.
  always_comb begin
    in_ready = (state_q == StIdle) && !rst;
    busy     = (state_q != StIdle);
  end

  // Conversion datapath: shadow digits build up, then load together at commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      frac_q      <= '0;
      rem_q       <= '0;
      int_rem_q   <= '0;
      tens_sh_q   <= '0;
      ones_sh_q   <= '0;
      tenths_sh_q <= '0;
      hund_sh_q   <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      tenths_q    <= '0;
      hund_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            frac_q    <= in_data[FRAC_W-1:0];
            int_rem_q <= RemW'(in_data[DataW-1:FRAC_W]);
            tens_sh_q <= '0;
          end
        end
        StFrac1: begin
          tenths_sh_q <= frac_x10[PW-1:FRAC_W];
          rem_q       <= frac_x10[FRAC_W-1:0];
        end
        StFrac2: hund_sh_q <= rem_x10[PW-1:FRAC_W];
        StInt: begin
          if (!int_done) begin
            int_rem_q <= int_rem_q - RemW'(10);
            tens_sh_q <= tens_sh_q + 4'd1;
          end else begin
            ones_sh_q <= int_rem_q[3:0];
          end
        end
        StCommit: begin
          tens_q   <= tens_sh_q;
          ones_q   <= ones_sh_q;
          tenths_q <= tenths_sh_q;
          hund_q   <= hund_sh_q;
        end
        default: ;
      endcase
    end
  end

  // Scan path: seg/dp are computed for the slot that becomes selected at the wrap edge.
  logic [CntW-1:0] cnt_q;
  logic [3:0]      sel_nxt, enc_digit;
  logic            enc_blank;
  logic [6:0]      enc_seg;

  assign sel_nxt = {dig_sel[2:0], dig_sel[3]};

  always_comb begin
    enc_digit = 4'd0;
    enc_blank = 1'b1;
    unique case (sel_nxt)
      4'b1000: begin enc_digit = tens_q;   enc_blank = (tens_q == 4'd0); end
      4'b0100: begin enc_digit = ones_q;   enc_blank = 1'b0;             end
      4'b0010: begin enc_digit = tenths_q; enc_blank = 1'b0;             end
      4'b0001: begin enc_digit = hund_q;   enc_blank = 1'b0;             end
      default: ;
    endcase
  end

  seg7_encoder u_seg7_encoder (
    .digit (enc_digit),
    .blank (enc_blank),
    .seg   (enc_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      dig_sel <= DIG_SEL_RESET;
      seg     <= SEG_BLANK;
      dp      <= 1'b0;
    end else if (cnt_q == CntW'(SCAN_DIV - 1)) begin
      cnt_q   <= '0;
      dig_sel <= sel_nxt;
      seg     <= enc_seg;
      dp      <= sel_nxt[2];
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
